fill_event_tracker: RTL and testbench
=====================================

# fill_event_tracker

Downstream consumer of the load/store stage's `sig` full indicator. Detects each full event (rising edge of `sig`), measures the cycle gap between consecutive events, counts events, and raises a watchdog flag when no event arrives within a bound. Gap measurements go out over a single-entry valid/ready port to a logging or checking stage.

## Interface
- `PBITS`, 16, width of gap counter and `period` output
- `CBITS`, 8, width of `events` counter
- `TIMEOUT`, 12000, gap in cycles at or above which `timeout` asserts; must be < 2^PBITS
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset asserted)
- `sig` in 1: full indicator from load/store stage, synchronous to `clk`
- `period_ready` in 1: consumer accepts `period` this cycle
- `period` out PBITS: measured gap between the last two events, in cycles
- `period_valid` out 1: `period` holds an unconsumed measurement
- `events` out CBITS: number of rising edges seen, saturating
- `tracking` out 1: FSM in TRACK (at least one event seen)
- `timeout` out 1: gap counter ≥ TIMEOUT
- `overrun` out 1: sticky; a measurement was dropped

## Operation
- Edge detect: `sig_d` register (reset 0). `rise = sig & ~sig_d`. A `sig` held high for several cycles is one event.
- Gap counter `gap_cnt` (PBITS, reset 0): on `rise` loads 0; otherwise increments, saturating at 2^PBITS−1.
- FSM, 2 states:
  - WAIT_FIRST (reset state): on `rise` → TRACK; no measurement emitted.
  - TRACK: on `rise` → produce measurement `gap_cnt + 1`, saturating at 2^PBITS−1; stay in TRACK. Only reset leaves TRACK.
- `events`: +1 on every `rise` in either state, saturating at 2^CBITS−1.
- Output register (single entry):
  - measurement produced, `period_valid`=0 → load `period`, set `period_valid`.
  - `period_valid & period_ready` with no new measurement → clear `period_valid`; `period` keeps last value.
  - measurement produced with `period_valid & period_ready` in same cycle → load new value, `period_valid` stays 1; no overrun.
  - measurement produced with `period_valid & ~period_ready` → new value dropped, `period` unchanged, `overrun` ← 1.
- `period` stable while `period_valid & ~period_ready`.
- `overrun` cleared only by reset.
- `timeout = (gap_cnt >= TIMEOUT)`, decoded from the registered counter. Active in both states, so it also covers a missing first event after reset.
- `tracking = (state == TRACK)`.

## Timing
- Reset (`rst`=0, asynchronous): `sig_d`, `gap_cnt`, `period`, `period_valid`, `events`, `overrun` all 0; state WAIT_FIRST. So `tracking`=0 and `timeout`=0.
- Reset release: the first edge with `rst`=1 samples normally. `sig`=1 on that edge counts as a rise, because `sig_d`=0.
- Latency: `sig` sampled high at edge k (low at k−1) → `events`, `period`, `period_valid`, and `tracking` updated after edge k.
- Gap definition: rises sampled at edges a and b → `period` = b−a.
- `timeout` rises after the edge where `gap_cnt` reaches TIMEOUT, i.e. TIMEOUT edges after the last rise. It falls after the next rise edge.
- Reset mid-transfer: pending `period_valid` is lost. No partial state survives.

## Test plan
- Reset: hold `rst`=0 with `sig` toggling → all outputs 0. Release with `sig`=1 → `events`=1 and `tracking`=1 after the first edge, `period_valid`=0.
- Steady stream, `period_ready`=1: rises at edges 5, 15, 25 → `period_valid` high one cycle after edges 15 and 25, `period`=10 each time, `events` 1→2→3, `overrun`=0.
- Back-pressure, `period_ready`=0: rises at edges 0, 10, 20, 30 → after edge 10 `period`=10 and valid. After edge 20, `overrun`=1 and `period` still 10. Raise ready at edge 35 → valid clears after edge 35.
- Simultaneous accept and new measurement: valid pending, `period_ready`=1 on the edge of a rise with gap 7 → `period`=7, valid stays 1, `overrun`=0.
- Watchdog, TIMEOUT=20: no `sig` for 30 cycles after reset → `timeout`=1 from edge 20. Rise at edge 30 → `timeout`=0 after edge 30, `tracking`=1.
- Saturation, PBITS=4, CBITS=2, TIMEOUT=10: rises at edges 0 and 20 → `period`=15. Five more rises → `events` stuck at 3.

Source files
------------

// File: rtl/fill_event_tracker.sv
// Full-event tracker: detects rising edges of the load/store full indicator,
// measures inter-event gaps, counts events and flags a missing-event watchdog.
`timescale 1ns/1ps

module fill_event_tracker #(
  parameter int PBITS   = 16,
  parameter int CBITS   = 8,
  parameter int TIMEOUT = 12000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             period_ready,
  output logic [PBITS-1:0] period,
  output logic             period_valid,
  output logic [CBITS-1:0] events,
  output logic             tracking,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [0:0]       WAIT_FIRST = 1'b0;
  localparam logic [0:0]       TRACK      = 1'b1;
  localparam logic [PBITS-1:0] PMAX       = {PBITS{1'b1}};
  localparam logic [CBITS-1:0] CMAX       = {CBITS{1'b1}};
  localparam logic [PBITS-1:0] TLIM       = PBITS'(TIMEOUT);

  function automatic logic [PBITS-1:0] sat_inc_p(input logic [PBITS-1:0] v);
    return (v == PMAX) ? v : v + PBITS'(1);
  endfunction

  function automatic logic [CBITS-1:0] sat_inc_c(input logic [CBITS-1:0] v);
    return (v == CMAX) ? v : v + CBITS'(1);
  endfunction

  logic             sig_d_r;
  logic [PBITS-1:0] gap_cnt_r;
  logic [0:0]       state_r;
  logic [PBITS-1:0] period_r;
  logic             period_valid_r;
  logic [CBITS-1:0] events_r;
  logic             overrun_r;
  logic             timeout_r;

  logic             rise_s;
  logic             meas_s;
  logic             accept_s;
  logic [PBITS-1:0] gap_next_s;
  logic [PBITS-1:0] meas_val_s;
  logic [0:0]       state_next_s;
  logic [PBITS-1:0] period_next_s;
  logic             period_valid_next_s;
  logic             overrun_next_s;
  logic [CBITS-1:0] events_next_s;

  // Next-state decode for edge detect, gap counter, FSM and output slot.
  always_comb begin
    rise_s              = sig & ~sig_d_r;
    meas_s              = 1'b0;
    accept_s            = period_valid_r & period_ready;
    meas_val_s          = sat_inc_p(gap_cnt_r);
    gap_next_s          = gap_cnt_r;
    state_next_s        = state_r;
    period_next_s       = period_r;
    period_valid_next_s = period_valid_r;
    overrun_next_s      = overrun_r;
    events_next_s       = events_r;

    if (rise_s) begin
      gap_next_s    = {PBITS{1'b0}};
      events_next_s = sat_inc_c(events_r);
    end else begin
      gap_next_s    = sat_inc_p(gap_cnt_r);
      events_next_s = events_r;
    end

    case (state_r)
      WAIT_FIRST: begin
        if (rise_s) begin
          state_next_s = TRACK;
        end else begin
          state_next_s = WAIT_FIRST;
        end
      end
      TRACK: begin
        state_next_s = TRACK;
        meas_s       = rise_s;
      end
      default: begin
        state_next_s = WAIT_FIRST;
      end
    endcase

    // A new measurement only lands if the slot is empty or being drained now.
    if (meas_s) begin
      if (!period_valid_r || accept_s) begin
        period_next_s       = meas_val_s;
        period_valid_next_s = 1'b1;
      end else begin
        overrun_next_s      = 1'b1;
      end
    end else if (accept_s) begin
      period_valid_next_s = 1'b0;
    end else begin
      period_valid_next_s = period_valid_r;
    end
  end

  // State registers; timeout is registered from the counter's next value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_d_r        <= 1'b0;
      gap_cnt_r      <= {PBITS{1'b0}};
      state_r        <= WAIT_FIRST;
      period_r       <= {PBITS{1'b0}};
      period_valid_r <= 1'b0;
      events_r       <= {CBITS{1'b0}};
      overrun_r      <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      sig_d_r        <= sig;
      gap_cnt_r      <= gap_next_s;
      state_r        <= state_next_s;
      period_r       <= period_next_s;
      period_valid_r <= period_valid_next_s;
      events_r       <= events_next_s;
      overrun_r      <= overrun_next_s;
      timeout_r      <= (gap_next_s >= TLIM);
    end
  end

  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign events       = events_r;
  assign tracking     = (state_r == TRACK);
  assign timeout      = timeout_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_fill_event_tracker.sv
// Scoreboard bench for fill_event_tracker: a cycle-number model predicts gaps,
// expected measurements are queued when produced and compared when consumed.
`timescale 1ns/1ps

module tb_fill_event_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig = 1'b0;
  logic        period_ready = 1'b0;
  logic [15:0] period;
  logic        period_valid;
  logic [7:0]  events;
  logic        tracking, timeout, overrun;

  logic        sig2 = 1'b0;
  logic [3:0]  period2;
  logic        period_valid2;
  logic [1:0]  events2;
  logic        tracking2, timeout2, overrun2;

  always #5 clk = ~clk;

  fill_event_tracker #(.PBITS(16), .CBITS(8), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .sig(sig), .period_ready(period_ready),
    .period(period), .period_valid(period_valid), .events(events),
    .tracking(tracking), .timeout(timeout), .overrun(overrun)
  );

  fill_event_tracker #(.PBITS(4), .CBITS(2), .TIMEOUT(10)) dut_sat (
    .clk(clk), .rst(rst), .sig(sig2), .period_ready(1'b1),
    .period(period2), .period_valid(period_valid2), .events(events2),
    .tracking(tracking2), .timeout(timeout2), .overrun(overrun2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model, in absolute edge numbers since reset release
  int cyc;
  int last_rise;
  bit have_rise;
  bit prev_sig;
  int m_events;
  bit m_valid;
  bit m_overrun;
  int q[$];

  task automatic model_reset();
    cyc = 0; last_rise = 0; have_rise = 0; prev_sig = 0;
    m_events = 0; m_valid = 0; m_overrun = 0;
    q.delete();
  endtask

  task automatic step(input bit s, input bit r, input bit s2);
    bit rise;
    int g;
    sig = s; period_ready = r; sig2 = s2;
    if (period_valid) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 0, 1);
      end else begin
        chk("period", int'(period), q[0]);
        if (r) void'(q.pop_front());
      end
    end
    @(posedge clk);
    cyc++;
    rise = s && !prev_sig;
    prev_sig = s;
    if (m_valid && r) m_valid = 0;
    if (rise) begin
      if (have_rise) begin
        g = cyc - last_rise;
        if (g > 65535) g = 65535;
        if (!m_valid) begin
          m_valid = 1;
          q.push_back(g);
        end else begin
          m_overrun = 1;
        end
      end
      have_rise = 1;
      last_rise = cyc;
      if (m_events < 255) m_events++;
    end
    #1;
    chk("period_valid", int'(period_valid), int'(m_valid));
    chk("events", int'(events), m_events);
    chk("tracking", int'(tracking), int'(have_rise));
    chk("overrun", int'(overrun), int'(m_overrun));
    chk("timeout", int'(timeout), ((cyc - last_rise) >= 20) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    period_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sig  = i[0];
      sig2 = ~i[0];
      @(posedge clk);
      #1;
    end
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_events", int'(events), 0);
    chk("rst_tracking", int'(tracking), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_events2", int'(events2), 0);
    chk("rst_tracking2", int'(tracking2), 0);
    sig = 1'b0; sig2 = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();

    // Release with sig already high counts as the first event
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("rel_events", int'(events), 1);
    chk("rel_tracking", int'(tracking), 1);
    chk("rel_valid", int'(period_valid), 0);
    step(1'b0, 1'b1, 1'b0);

    // Steady stream, always ready
    do_reset();
    for (int e = 1; e <= 30; e++) step(e == 5 || e == 15 || e == 25, 1'b1, 1'b0);
    chk("steady_period", int'(period), 10);
    chk("steady_overrun", int'(overrun), 0);

    // Back-pressure: second and third measurements dropped
    do_reset();
    for (int e = 1; e <= 40; e++)
      step(e == 1 || e == 11 || e == 21 || e == 31, e >= 36, 1'b0);
    chk("bp_period", int'(period), 10);
    chk("bp_overrun", int'(overrun), 1);

    // Accept and new measurement on the same edge
    do_reset();
    for (int e = 1; e <= 15; e++) step(e == 1 || e == 8 || e == 15, e == 15, 1'b0);
    chk("sim_valid", int'(period_valid), 1);
    chk("sim_period", int'(period), 7);
    chk("sim_overrun", int'(overrun), 0);
    step(1'b0, 1'b1, 1'b0);

    // Watchdog with no first event
    do_reset();
    for (int e = 1; e <= 30; e++) step(e == 30, 1'b1, 1'b0);
    chk("wd_timeout", int'(timeout), 0);
    chk("wd_tracking", int'(tracking), 1);

    // Saturation on the narrow instance
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step(1'b0, 1'b1, e == 1 || e == 21 || e == 24 || e == 27 || e == 30 || e == 33 || e == 36);
      if (e == 20) chk("sat_timeout2", int'(timeout2), 1);
      if (e == 21) begin
        chk("sat_period2", int'(period2), 15);
        chk("sat_valid2", int'(period_valid2), 1);
      end
    end
    chk("sat_events2", int'(events2), 3);
    chk("sat_overrun2", int'(overrun2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
